// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder stage: default sizes, the
// index bit-reversal helper and the read-side state encoding.
package fft_pkg;

   localparam int unsigned FFT_N_LOG2  = 6;
   localparam int unsigned FFT_WIDTH   = 16;
   localparam int unsigned BITREV_MAX  = 16;
   localparam int unsigned BITREV_IDXW = 4;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_e;

   // Reverse the low n bits of x; bits at or above n come back as zero.
   function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] x,
                                                    input int unsigned n);
      logic [BITREV_MAX-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < BITREV_MAX; i++) begin
         if (i < n) r[BITREV_IDXW'(i)] = x[BITREV_IDXW'(n - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// The read register only updates on a read, so its output holds between bursts.
module fft_reorder_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[raddr];
   end

   always_ff @(posedge clock) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder buffer behind the 64-point SDF FFT.
// Define FFT_REORDER_LAST_EN to add the do_last end-of-burst marker.
module fft_reorder
   import fft_pkg::*;
#(
   parameter int unsigned WIDTH  = FFT_WIDTH,
   parameter int unsigned N_LOG2 = FFT_N_LOG2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             di_en,
   input  logic [WIDTH-1:0] di_re,
   input  logic [WIDTH-1:0] di_im,
`ifdef FFT_REORDER_LAST_EN
   output logic             do_last,
`endif
   output logic             do_en,
   output logic [WIDTH-1:0] do_re,
   output logic [WIDTH-1:0] do_im
);

   localparam int unsigned N      = 1 << N_LOG2;
   localparam int unsigned ADDR_W = N_LOG2 + 1;
   localparam int unsigned DATA_W = 2 * WIDTH;

   logic [N_LOG2-1:0] wcnt_q, wcnt_d;
   logic              wbank_q, wbank_d;
   logic [1:0]        full_q, full_d;
   rd_state_e         state_q, state_d;
   logic [N_LOG2-1:0] raddr_q, raddr_d;
   logic              rbank_q, rbank_d;
   logic              do_en_q, do_en_d;
   logic              do_last_q, do_last_d;

   logic              wcnt_last_c, raddr_last_c, rd_en_c;
   logic [1:0]        full_set_c, full_clr_c;
   logic [ADDR_W-1:0] ram_waddr_c, ram_raddr_c;
   logic [DATA_W-1:0] ram_rdata;

   assign wcnt_last_c  = (wcnt_q == N_LOG2'(N - 1));
   assign raddr_last_c = (raddr_q == N_LOG2'(N - 1));

   // Write side: store each sample at its natural index inside the current bank.
   always_comb begin
      wcnt_d     = wcnt_q;
      wbank_d    = wbank_q;
      full_set_c = '0;
      if (di_en) begin
         wcnt_d = wcnt_q + N_LOG2'(1);
         if (wcnt_last_c) begin
            full_set_c[wbank_q] = 1'b1;
            wbank_d             = ~wbank_q;
         end
      end
   end

   // Read side: replay a full bank as one gap-free burst, chaining into the other bank.
   always_comb begin
      state_d    = state_q;
      raddr_d    = raddr_q;
      rbank_d    = rbank_q;
      full_clr_c = '0;
      rd_en_c    = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (full_q[rbank_q]) begin
               state_d = RD_READ;
               raddr_d = '0;
            end
         end
         RD_READ: begin
            rd_en_c = 1'b1;
            raddr_d = raddr_q + N_LOG2'(1);
            if (raddr_last_c) begin
               full_clr_c[rbank_q] = 1'b1;
               rbank_d             = ~rbank_q;
               state_d             = full_q[~rbank_q] ? RD_READ : RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // Set and clear always address different banks, so they simply combine.
   always_comb begin
      full_d    = (full_q | full_set_c) & ~full_clr_c;
      do_en_d   = rd_en_c;
      do_last_d = rd_en_c & raddr_last_c;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wcnt_q    <= '0;
         wbank_q   <= 1'b0;
         full_q    <= '0;
         state_q   <= RD_IDLE;
         raddr_q   <= '0;
         rbank_q   <= 1'b0;
         do_en_q   <= 1'b0;
         do_last_q <= 1'b0;
      end else begin
         wcnt_q    <= wcnt_d;
         wbank_q   <= wbank_d;
         full_q    <= full_d;
         state_q   <= state_d;
         raddr_q   <= raddr_d;
         rbank_q   <= rbank_d;
         do_en_q   <= do_en_d;
         do_last_q <= do_last_d;
      end
   end

   assign ram_waddr_c = {wbank_q, N_LOG2'(bitrev(BITREV_MAX'(wcnt_q), N_LOG2))};
   assign ram_raddr_c = {rbank_q, raddr_q};

   fft_reorder_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock (clock),
      .reset (reset),
      .we    (di_en),
      .waddr (ram_waddr_c),
      .wdata ({di_re, di_im}),
      .re    (rd_en_c),
      .raddr (ram_raddr_c),
      .rdata (ram_rdata)
   );

   assign do_en = do_en_q;
   assign do_re = ram_rdata[DATA_W-1:WIDTH];
   assign do_im = ram_rdata[WIDTH-1:0];
`ifdef FFT_REORDER_LAST_EN
   assign do_last = do_last_q;
`else
   logic unused_last;
   assign unused_last = do_last_q;
`endif

   // A bank may only be refilled once its replay has drained it.
   a_no_overwrite: assert property (@(posedge clock) disable iff (reset)
      !(di_en && full_q[wbank_q] && !full_clr_c[wbank_q]));

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder: a frame-level model predicts natural-order
// bursts and their start cycles; a monitor checks every output cycle.
module tb_fft_reorder;

   localparam int NPT = 64;

   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
   } samp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        di_en = 1'b0;
   logic [15:0] di_re = '0;
   logic [15:0] di_im = '0;
   logic        do_en;
   logic [15:0] do_re;
   logic [15:0] do_im;
`ifdef FFT_REORDER_LAST_EN
   logic        do_last;
`endif

   fft_reorder dut (
      .clock   (clock),
      .reset   (reset),
      .di_en   (di_en),
      .di_re   (di_re),
      .di_im   (di_im),
`ifdef FFT_REORDER_LAST_EN
      .do_last (do_last),
`endif
      .do_en   (do_en),
      .do_re   (do_re),
      .do_im   (do_im)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: arrival-order frame being collected, plus expected outputs.
   logic [15:0] fin_re [NPT];
   logic [15:0] fin_im [NPT];
   int          fcnt = 0;
   int          last_start = -1000;
   samp_t       exp_q[$];
   int          start_q[$];

   int          burst_cnt = 0;
   logic [15:0] hold_re = '0;
   logic [15:0] hold_im = '0;

   function automatic int brev6(input int x);
      int r = 0;
      for (int i = 0; i < 6; i++) r = (r << 1) | ((x >> i) & 1);
      return r;
   endfunction

   // Arrival position p carries X[brev(p)], so X[k] is the sample that arrived at brev(k).
   task automatic model_accept(input logic [15:0] re, input logic [15:0] im, input int k);
      int st;
      samp_t s;
      fin_re[fcnt] = re;
      fin_im[fcnt] = im;
      fcnt++;
      if (fcnt == NPT) begin
         for (int x = 0; x < NPT; x++) begin
            s.re = fin_re[brev6(x)];
            s.im = fin_im[brev6(x)];
            exp_q.push_back(s);
         end
         st = (k + 3 > last_start + NPT) ? k + 3 : last_start + NPT;
         start_q.push_back(st);
         last_start = st;
         fcnt = 0;
      end
   endtask

   task automatic send(input logic [15:0] re, input logic [15:0] im, input int gap);
      @(negedge clock);
      di_en = 1'b1;
      di_re = re;
      di_im = im;
      model_accept(re, im, cyc);
      repeat (gap) begin
         @(negedge clock);
         di_en = 1'b0;
         di_re = 16'($urandom);
         di_im = 16'($urandom);
      end
   endtask

   task automatic stop_input();
      @(negedge clock);
      di_en = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || burst_cnt != 0) && t < 500) begin
         @(negedge clock);
         t++;
      end
      if (t >= 500) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d samples still expected", exp_q.size());
      end
   endtask

   task automatic check_idle_outputs(input string name);
      n_tests++;
      if (do_en !== 1'b0 || do_re !== 16'h0 || do_im !== 16'h0) begin
         n_fail++;
         $display("FAIL %s: got en=%b re=%h im=%h, want en=0 re=0000 im=0000",
                  name, do_en, do_re, do_im);
      end
`ifdef FFT_REORDER_LAST_EN
      n_tests++;
      if (do_last !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_last: got %b, want 0", name, do_last);
      end
`endif
   endtask

   task automatic do_reset(input string name);
      @(negedge clock);
      reset = 1'b1;
      di_en = 1'b0;
      repeat (2) @(negedge clock);
      check_idle_outputs(name);
      reset = 1'b0;
      fcnt = 0;
      last_start = -1000;
      exp_q.delete();
      start_q.delete();
   endtask

   // Monitor: compare every valid output; between bursts outputs must hold.
   always @(negedge clock) begin
      samp_t e;
      int    st;
      if (reset) begin
         burst_cnt = 0;
         hold_re   = '0;
         hold_im   = '0;
      end else if (do_en) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_do_en: cyc=%0d re=%h im=%h", cyc, do_re, do_im);
         end else begin
            e = exp_q.pop_front();
            if (burst_cnt == 0) begin
               st = start_q.pop_front();
               n_tests++;
               if (cyc != st) begin
                  n_fail++;
                  $display("FAIL burst_start: got cyc %0d, want cyc %0d", cyc, st);
               end
            end
            n_tests++;
            if (do_re !== e.re || do_im !== e.im) begin
               n_fail++;
               $display("FAIL sample[%0d]: got re=%h im=%h, want re=%h im=%h",
                        burst_cnt, do_re, do_im, e.re, e.im);
            end
`ifdef FFT_REORDER_LAST_EN
            n_tests++;
            if (do_last !== (burst_cnt == NPT - 1)) begin
               n_fail++;
               $display("FAIL do_last[%0d]: got %b, want %b",
                        burst_cnt, do_last, burst_cnt == NPT - 1);
            end
`endif
            hold_re   = e.re;
            hold_im   = e.im;
            burst_cnt = (burst_cnt == NPT - 1) ? 0 : burst_cnt + 1;
         end
      end else begin
         if (burst_cnt != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL burst_gap: do_en low after %0d samples at cyc %0d", burst_cnt, cyc);
            burst_cnt = 0;
         end
         n_tests++;
         if (do_re !== hold_re || do_im !== hold_im) begin
            n_fail++;
            $display("FAIL hold: got re=%h im=%h, want re=%h im=%h",
                     do_re, do_im, hold_re, hold_im);
         end
`ifdef FFT_REORDER_LAST_EN
         n_tests++;
         if (do_last !== 1'b0) begin
            n_fail++;
            $display("FAIL do_last_idle: got %b, want 0", do_last);
         end
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ext [4];
      logic [15:0] v;
      ext[0] = 16'h8000;
      ext[1] = 16'h7FFF;
      ext[2] = 16'h0000;
      ext[3] = 16'hFFFF;

      do_reset("reset_state");

      // Ramp: continuous bit-reversed ramp comes out as 0..63 / 0..-63.
      for (int n = 0; n < NPT; n++) begin
         v = 16'(brev6(n));
         send(v, 16'(-v), 0);
      end
      stop_input();
      drain();

      // Same ramp, one input every third cycle.
      for (int n = 0; n < NPT; n++) begin
         v = 16'(brev6(n));
         send(v, 16'(-v), 2);
      end
      stop_input();
      drain();

      // Three back-to-back random frames.
      for (int n = 0; n < 3 * NPT; n++) send(16'($urandom), 16'($urandom), 0);
      stop_input();
      drain();

      // Partial frame discarded by reset, then one clean frame.
      for (int n = 0; n < 30; n++) send(16'($urandom), 16'($urandom), 0);
      do_reset("reset_mid_frame");
      for (int n = 0; n < NPT; n++) send(16'($urandom), 16'($urandom), 0);
      stop_input();
      drain();

      // Extreme values on both components.
      for (int n = 0; n < 2 * NPT; n++)
         send(ext[$urandom_range(0, 3)], ext[$urandom_range(0, 3)], 0);
      stop_input();
      drain();

      // Randomly gapped frames.
      for (int n = 0; n < 3 * NPT; n++)
         send(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      stop_input();
      drain();

      repeat (5) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
